inst_fetch: RTL and testbench
=============================

# inst_fetch

Program-counter sequencer that drives the instruction ROM address. It owns the PC register and advances it every cycle, or redirects it on relative branches and absolute jumps. It holds the PC on stall, stops on halt, and counts retired instructions. It sits between the control/decode logic and InstROM; the combinational InstROM output presents the instruction for the current address in the same cycle.

## Interface
- AW, 16, address width; matches InstROM InstAddress width
- OW, 8, signed branch-offset width

- CLK  in  1  system clock, rising-edge active
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  pulse; begins execution at StartAddr (honoured in IDLE or HALT only)
- StartAddr  in  AW  first instruction address
- Stall  in  1  hold PC this cycle
- Jump  in  1  absolute redirect: PC <= JumpTarget
- JumpTarget  in  AW  jump destination
- BranchRel  in  1  relative redirect: PC <= PC + sext(BranchOffset)
- BranchOffset  in  OW  two's-complement offset, relative to current PC
- Halt  in  1  stop execution after the current instruction
- InstAddress  out  AW  registered PC; drives InstROM
- Running  out  1  high while in RUN
- Done  out  1  one-cycle pulse on entry to HALT
- InstCount  out  AW  retired-instruction count, saturating

## Operation
- States: IDLE, RUN, HALT. Encoding is free.
- IDLE: PC holds. Start=1 loads PC<=StartAddr, clears InstCount to 0, and moves to RUN.
- RUN, per-cycle priority, highest first:
  - Halt: PC holds; go to HALT; Done=1 next cycle.
  - Stall: PC holds.
  - Jump: PC<=JumpTarget.
  - BranchRel: PC<=PC+sext(BranchOffset).
  - Otherwise: PC<=PC+1.
- HALT: PC holds and Done returns to 0 after one cycle. Start=1 reloads exactly as from IDLE; there is no other exit.
- Start during RUN is ignored. Jump, BranchRel, Stall and Halt are ignored outside RUN.
- Arithmetic:
  - All PC updates are modulo 2^AW. 0xFFFF+1 = 0x0000, and branches wrap in both directions.
  - BranchOffset is sign-extended to AW before the add.
- InstCount:
  - Increments in every RUN cycle where Stall=0, including the cycle in which Halt is sampled.
  - A cycle with Halt=1 and Stall=1 halts without incrementing.
  - Saturates at 2^AW-1; no wrap.
- Running=1 exactly when state==RUN.

## Timing
- Reset (async assert, sync release to CLK):
  - state=IDLE, InstAddress=0, Running=0, Done=0, InstCount=0.
  - All of these values apply immediately on Reset_n falling, including mid-RUN.
- All outputs are registered. No combinational path from any input to any output.
- Start accepted at edge N gives InstAddress=StartAddr and Running=1 after edge N.
- Redirect latency is 1 cycle. A Jump or BranchRel sampled at edge N is visible on InstAddress after edge N. There is no delay slot and no bubble.
- Halt sampled at edge N gives Running=0 and Done=1 for the cycle after edge N. InstAddress stays at the halting instruction.
- Start and Halt in the same RUN cycle: Start is ignored and Halt is taken.
- Jump and BranchRel together: Jump wins.

## Test plan
- Reset/sequential fetch:
  - Stimulus: hold Reset_n=0, then release; pulse Start with StartAddr=0; run 10 cycles.
  - Required: outputs read all zero during reset; InstAddress steps 0,1,…,10 and InstCount reads 10.
- Branch/jump:
  - Stimulus: at PC=5, BranchRel=1 with BranchOffset=8'hFD (−3). Later, Jump=1 with BranchRel=1 and JumpTarget=16'h0100.
  - Required: next PC=2. For the jump, next PC=0x0100 (Jump priority).
- Stall:
  - Stimulus: Stall=1 for 3 cycles at PC=7.
  - Required: InstAddress holds 7 and InstCount is unchanged for those 3 cycles. PC=8 one cycle after Stall drops.
- Halt/Done:
  - Stimulus: Halt=1 at PC=4 after 4 retired instructions. Then pulse Start with StartAddr=16'h0020.
  - Required: Done high exactly one cycle, Running=0, InstAddress=4, InstCount=5. After Start: InstCount=0 and PC=0x0020 with Running=1.
- Wrap:
  - Stimulus: StartAddr=16'hFFFE, run 3 cycles. Separately, at PC=1 issue BranchOffset=8'hFE (−2).
  - Required: PC sequence FFFE, FFFF, 0000, 0001. The branch gives PC=FFFF.
- Reset mid-run:
  - Stimulus: assert Reset_n=0 between edges while in RUN at PC=0x0033.
  - Required: InstAddress=0, Running=0 and InstCount=0 before the next CLK edge. Start is still required to resume.

Source files
------------

// File: rtl/inst_fetch.sv
// Program-counter sequencer: owns the PC that addresses InstROM, steps it
// every RUN cycle, redirects on jumps/relative branches, and counts retired
// instructions with saturation.
module inst_fetch #(
  parameter int unsigned AW = 16,
  parameter int unsigned OW = 8
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  input  logic          Stall,
  input  logic          Jump,
  input  logic [AW-1:0] JumpTarget,
  input  logic          BranchRel,
  input  logic [OW-1:0] BranchOffset,
  input  logic          Halt,
  output logic [AW-1:0] InstAddress,
  output logic          Running,
  output logic          Done,
  output logic [AW-1:0] InstCount
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  localparam logic [AW-1:0] CountMax = {AW{1'b1}};

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [AW-1:0] branch_off;

  // Sign-extend the branch offset to address width; the add wraps mod 2^AW.
  assign branch_off = {{(AW-OW){BranchOffset[OW-1]}}, BranchOffset};

  // Next-state, PC and counter update; Halt > Stall > Jump > BranchRel > +1.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle, StHalt: begin
        if (Start) begin
          pc_d    = StartAddr;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // The halting instruction still retires unless it is also stalled.
        if (!Stall && (cnt_q != CountMax)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (Halt) begin
          state_d = StHalt;
          done_d  = 1'b1;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (Jump) begin
          pc_d = JumpTarget;
        end else if (BranchRel) begin
          pc_d = pc_q + branch_off;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign InstAddress = pc_q;
  assign Running     = (state_q == StRun);
  assign Done        = done_q;
  assign InstCount   = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random
// traffic, all compared against a behavioural model of the sequencer.
module tb_inst_fetch;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [15:0] StartAddr;
  logic        Stall;
  logic        Jump;
  logic [15:0] JumpTarget;
  logic        BranchRel;
  logic [7:0]  BranchOffset;
  logic        Halt;
  logic [15:0] InstAddress;
  logic        Running;
  logic        Done;
  logic [15:0] InstCount;

  int n_cmp = 0;
  int n_err = 0;

  // Model: mode 0 = idle, 1 = run, 2 = halt.
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;
  int m_done = 0;

  inst_fetch #(.AW(16), .OW(8)) dut (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .StartAddr    (StartAddr),
    .Stall        (Stall),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .BranchRel    (BranchRel),
    .BranchOffset (BranchOffset),
    .Halt         (Halt),
    .InstAddress  (InstAddress),
    .Running      (Running),
    .Done         (Done),
    .InstCount    (InstCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},   32'(InstAddress), 32'(m_pc));
    check({tag, ".run"},  32'(Running),     32'(m_mode == 1));
    check({tag, ".done"}, 32'(Done),        32'(m_done));
    check({tag, ".cnt"},  32'(InstCount),   32'(m_cnt));
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_cnt  = 0;
    m_done = 0;
  endtask

  // Advance the model one cycle from the inputs currently driven.
  task automatic model_step();
    m_done = 0;
    if (m_mode != 1) begin
      if (Start) begin
        m_pc   = int'(StartAddr);
        m_cnt  = 0;
        m_mode = 1;
      end
    end else begin
      if (!Stall && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (Halt) begin
        m_mode = 2;
        m_done = 1;
      end else if (!Stall) begin
        if (Jump)           m_pc = int'(JumpTarget);
        else if (BranchRel) m_pc = (m_pc + int'($signed(BranchOffset)) + 65536) % 65536;
        else                m_pc = (m_pc + 1) % 65536;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare 1 time unit after the edge.
  task automatic step(input string tag, input logic st, input logic [15:0] sa,
                      input logic sl, input logic j, input logic [15:0] jt,
                      input logic br, input logic [7:0] bo, input logic h);
    Start = st; StartAddr = sa; Stall = sl; Jump = j; JumpTarget = jt;
    BranchRel = br; BranchOffset = bo; Halt = h;
    model_step();
    @(posedge CLK);
    #1;
    check_model(tag);
    Start = 1'b0; Stall = 1'b0; Jump = 1'b0; BranchRel = 1'b0; Halt = 1'b0;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
  endtask

  initial begin
    Reset_n = 1'b0;
    Start = 1'b0; StartAddr = '0; Stall = 1'b0; Jump = 1'b0; JumpTarget = '0;
    BranchRel = 1'b0; BranchOffset = '0; Halt = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_model("reset");
    @(negedge CLK);
    Reset_n = 1'b1;

    // IDLE holds without Start, even with RUN-only controls asserted.
    step("idle_ign", 1'b0, 16'h0, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h0, 1'b0);
    check("idle_pc", 32'(InstAddress), 32'h0);

    // Sequential fetch from 0.
    step("start0", 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    for (int i = 0; i < 10; i++) idle("seq");
    check("seq_pc", 32'(InstAddress), 32'd10);
    check("seq_cnt", 32'(InstCount), 32'd10);

    // Relative branch back by 3, then Jump beats BranchRel.
    step("jmp5", 1'b0, 16'h0, 1'b0, 1'b1, 16'h0005, 1'b0, 8'h0, 1'b0);
    step("br_m3", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 8'hFD, 1'b0);
    check("br_m3_pc", 32'(InstAddress), 32'h0002);
    step("jmp_pri", 1'b0, 16'h0, 1'b0, 1'b1, 16'h0100, 1'b1, 8'h05, 1'b0);
    check("jmp_pri_pc", 32'(InstAddress), 32'h0100);

    // Stall holds PC and count for three cycles at PC=7.
    step("jmp7", 1'b0, 16'h0, 1'b0, 1'b1, 16'h0007, 1'b0, 8'h0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, 16'h0, 1'b1, 1'b1, 16'h0F00, 1'b1, 8'h10, 1'b0);
    check("stall_pc", 32'(InstAddress), 32'h0007);
    idle("unstall");
    check("unstall_pc", 32'(InstAddress), 32'h0008);

    // Start during RUN is ignored; Start+Halt together takes Halt.
    step("start_run", 1'b1, 16'h0500, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    step("start_halt", 1'b1, 16'h0600, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
    check("start_halt_run", 32'(Running), 32'd0);

    // Halt at PC=4 after four retired instructions.
    step("restart0", 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    for (int i = 0; i < 4; i++) idle("pre_halt");
    step("halt", 1'b0, 16'h0, 1'b0, 1'b1, 16'h0999, 1'b0, 8'h0, 1'b1);
    check("halt_done", 32'(Done), 32'd1);
    check("halt_pc", 32'(InstAddress), 32'h0004);
    check("halt_cnt", 32'(InstCount), 32'd5);
    step("halt_ign", 1'b0, 16'h0, 1'b0, 1'b1, 16'h0777, 1'b1, 8'h3, 1'b1);
    check("done_drop", 32'(Done), 32'd0);
    step("start20", 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    check("start20_pc", 32'(InstAddress), 32'h0020);
    check("start20_cnt", 32'(InstCount), 32'd0);

    // Halt together with Stall halts without retiring.
    idle("pre_hs");
    step("halt_stall", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1);
    check("halt_stall_cnt", 32'(InstCount), 32'd1);

    // Wrap forward from FFFE and backward from 1.
    step("startFFFE", 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    idle("wrap1");
    idle("wrap2");
    check("wrap_zero", 32'(InstAddress), 32'h0000);
    idle("wrap3");
    step("br_m2", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 8'hFE, 1'b0);
    check("br_wrap_pc", 32'(InstAddress), 32'hFFFF);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 9) == 0), 16'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0), 16'($urandom),
           1'($urandom_range(0, 3) == 0), 8'($urandom),
           1'($urandom_range(0, 24) == 0));
    end

    // Asynchronous reset mid-run at PC=0x0033.
    step("restart_r", 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    step("jmp33", 1'b0, 16'h0, 1'b0, 1'b1, 16'h0033, 1'b0, 8'h0, 1'b0);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    @(negedge CLK);
    Reset_n = 1'b1;
    idle("post_rst");
    check("post_rst_run", 32'(Running), 32'd0);
    step("resume", 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    idle("resume2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
